// File: rtl/rr_first_one_finder.sv
// rtl/rr_first_one_finder.sv - registered round-robin find-first-one with valid/ready result stage
module rr_first_one_finder #(
  parameter int VECTOR_LENGTH = 16,
  parameter int INDEX_WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [VECTOR_LENGTH-1:0] vector_input,
  input  logic                     rr_mode_in,
  input  logic                     request_valid_in,
  output logic                     request_ready_out,
  output logic                     result_valid_out,
  input  logic                     result_ready_in,
  output logic [INDEX_WIDTH-1:0]   first_one_index_out,
  output logic [VECTOR_LENGTH-1:0] onehot_out,
  output logic                     found_out,
  output logic [INDEX_WIDTH-1:0]   pointer_out
);

  // Internal index/pointer width; outputs are zero-extended to INDEX_WIDTH.
  localparam int PW = $clog2(VECTOR_LENGTH);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t                   r_state;
  logic [PW-1:0]            r_index;
  logic [PW-1:0]            r_pointer;
  logic [VECTOR_LENGTH-1:0] r_onehot;
  logic                     r_found;

  logic                     w_accept;
  logic [PW-1:0]            w_start;
  logic [PW:0]              w_cand;
  logic                     w_found;
  logic [PW-1:0]            w_index;
  logic [VECTOR_LENGTH-1:0] w_onehot;
  logic [PW-1:0]            w_next_pointer;

  assign request_ready_out = (r_state == S_EMPTY) || result_ready_in;
  assign w_accept          = request_valid_in && request_ready_out;
  assign w_start           = rr_mode_in ? r_pointer : '0;

  // Scan candidates from the start position, wrapping by compare so non-power-of-2 lengths work.
  always_comb begin
    w_cand  = '0;
    w_found = 1'b0;
    w_index = '0;
    for (int k = 0; k < VECTOR_LENGTH; k++) begin
      w_cand = {1'b0, w_start} + (PW+1)'(k);
      if (w_cand >= (PW+1)'(VECTOR_LENGTH)) begin
        w_cand = w_cand - (PW+1)'(VECTOR_LENGTH);
      end
      if (!w_found && vector_input[w_cand[PW-1:0]]) begin
        w_found = 1'b1;
        w_index = w_cand[PW-1:0];
      end
    end
  end

  // Derive the one-hot grant and the pointer that follows the selected slot.
  always_comb begin
    w_onehot       = w_found ? (VECTOR_LENGTH'(1) << w_index) : '0;
    w_next_pointer = (w_index == PW'(VECTOR_LENGTH - 1)) ? '0 : (w_index + PW'(1));
  end

  // Result stage FSM: accept loads a new result, consume-only empties, reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_EMPTY;
      r_index   <= '0;
      r_onehot  <= '0;
      r_found   <= 1'b0;
      r_pointer <= '0;
    end else if (w_accept) begin
      r_state  <= S_FULL;
      r_index  <= w_index;
      r_onehot <= w_onehot;
      r_found  <= w_found;
      if (rr_mode_in && w_found) begin
        r_pointer <= w_next_pointer;
      end
    end else if ((r_state == S_FULL) && result_ready_in) begin
      r_state <= S_EMPTY;
    end
  end

  assign result_valid_out    = (r_state == S_FULL);
  assign first_one_index_out = INDEX_WIDTH'(r_index);
  assign onehot_out          = r_onehot;
  assign found_out           = r_found;
  assign pointer_out         = INDEX_WIDTH'(r_pointer);

endmodule
